uart_receiver: RTL and testbench
================================

# uart_receiver

Serial receive half of the UART 16550 core, the counterpart of the transmit path. Oversamples `srx_pad_i` at 16x baud using the shared baud `enable` tick, recovers 5–8 bit characters framed per `lcr`, checks parity, framing and break, and pushes each character with its status bits into a 16-entry receive FIFO. Also maintains the character-timeout counter used by the register block for the RX timeout interrupt.

## Interface
- `RF_DEPTH`, 16: receive FIFO entries.
- `RF_WIDTH`, 11: FIFO word; [10:3] data, [2] break, [1] framing error, [0] parity error.
- `clk` in 1: core clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `lcr` in 8: line control; [1:0] word length, [2] stop bits, [3] PE, [4] EP, [5] SP.
- `enable` in 1: 16x baud tick, one `clk` wide.
- `srx_pad_i` in 1: serial input, asynchronous to `clk`.
- `rf_pop` in 1: one-cycle pop strobe from the register block.
- `rx_reset` in 1: FIFO flush, synchronous.
- `lsr_mask` in 1: LSR read; clears the sticky overrun.
- `rf_data_out` out 11: FIFO head word.
- `rf_count` out 5: FIFO occupancy, 0..16.
- `rf_overrun` out 1: sticky overrun.
- `rf_error_bit` out 1: any stored word has PE, FE or BI set.
- `rstate` out 3: receiver state, for debug.
- `counter_t` out 10: timeout counter.

## Operation
- Input passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value `srx`.
- All state changes except FIFO ops and sync happen only on `enable` cycles.
- States: `s_idle`(0), `s_rec_start`(1), `s_rec_bit`(2), `s_rec_parity`(3), `s_rec_stop`(4), `s_push`(5), `s_wait_high`(6).
- `s_idle`: `srx==0` loads `rcounter=7` and goes to `s_rec_start`.
- `s_rec_start`: decrement. At 0, if `srx==1` it is a false start and returns to `s_idle` with no push. Otherwise load 15, clear the shift register, and load `bits=5+lcr[1:0]`.
- `s_rec_bit`: at `rcounter==0`, shift in `srx` LSB-first and reload 15. After the last bit, go to `s_rec_parity` if `lcr[3]`, else `s_rec_stop`.
- `s_rec_parity`: sample at 0. Expected parity by {EP,SP}:
  - 00: ~^data
  - 01: 1
  - 10: ^data
  - 11: 0
  - PE = sample != expected.
- `s_rec_stop`: sample at 0. FE = `srx==0`. Only the first stop bit is checked. Then go to `s_push`.
- `s_push`: one-cycle `rf_push` on the next `clk`, independent of `enable`.
  - Word = data zero-extended to 8 bits, with BI, FE, PE.
  - BI = data==0 && parity sample==0 (if enabled) && FE.
  - Next state is `s_wait_high` if BI, else `s_idle`.
- `s_wait_high`: stay until `srx==1`, then go to `s_idle`.
- FIFO full on push: word dropped, `rf_overrun` set. The flag clears on `lsr_mask` or `rx_reset`; set wins if both occur in the same cycle.
- Simultaneous push and pop: count unchanged, data preserved.
- Pop when empty: ignored.
- `rx_reset`: FIFO emptied, error tracking cleared. The receive FSM is unaffected.
- Timeout counter:
  - Frame bits F = 1 + (5+lcr[1:0]) + PE + (lcr[2] ? 2 : 1); reload value = 64·F − 1.
  - Reload on `rf_push`, `rf_pop`, or `rf_count==0`.
  - Otherwise decrement on `enable`, saturating at 0.

## Timing
- Reset values: `rstate`=0, `rf_count`=0, `rf_data_out`=0, `rf_overrun`=0, `rf_error_bit`=0, `counter_t`=0, sync flops=1.
- Synchronizer latency: 2 `clk`.
- Bit sampling: start sampled 8 ticks after the first low tick; each later bit 16 ticks apart.
- Push timing: 8N1 push lands at tick 152 after start detect, plus 1 `clk`.
- Reset mid-frame: immediately returns to `s_idle`. No partial push.
- `rf_count` updates in the `clk` after push or pop. `rf_data_out` reflects the new head in the same cycle as the count update.

## Structure
- Shared `uart_defines`:
  - `UART_FIFO_REC_WIDTH`=11 and `UART_FIFO_COUNTER_W`=5.
  - LCR bit indices: `UART_LC_PE`, `UART_LC_EP`, `UART_LC_SP`, `UART_LC_SB`, `UART_LC_BITS`.
  - State encodings.
- Sub-module `uart_rfifo`: 16×11 storage, count, overrun, and `error_bit` computed by a per-entry OR.

## Test plan
- 8N1, `lcr`=0x03, send 0xA5: one push, `rf_data_out`=0x528, `rf_count`=1.
- Glitch: `srx` low for 3 ticks only: returns to `s_idle`, `rf_count` stays 0.
- 7E1, `lcr`=0x1A, send 0x41 with parity bit 1: word [0]=1, `rf_error_bit`=1.
- Break: hold `srx` low for 2 frames at 8N1: one word 0x006 (BI, FE), FSM in `s_wait_high` until `srx` goes high, no second push.
- Overrun:
  - 17 characters with no pops: `rf_count`=16, `rf_overrun`=1.
  - `lsr_mask` pulse clears `rf_overrun`.
  - Head word is still the first character.
- Timeout:
  - 8N1, one char received, no pop: `counter_t` reloads to 639 and reaches 0 after 639 enables.
  - A `rf_pop` reloads it, and `rf_count`=0 holds it at the reload value.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART receive constants, LCR bit map, state encoding
// Purpose: constants and helpers shared by uart_receiver and uart_rfifo.
// Ports: none (package).
package uart_receiver_pkg;

  localparam int UART_FIFO_REC_WIDTH = 11;
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_POINTER_W = 4;

  // LCR bit indices; word length occupies [UART_LC_BITS +: 2]
  localparam int UART_LC_BITS = 0;
  localparam int UART_LC_SB   = 2;
  localparam int UART_LC_PE   = 3;
  localparam int UART_LC_EP   = 4;
  localparam int UART_LC_SP   = 5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC_START  = 3'd1,
    S_REC_BIT    = 3'd2,
    S_REC_PARITY = 3'd3,
    S_REC_STOP   = 3'd4,
    S_PUSH       = 3'd5,
    S_WAIT_HIGH  = 3'd6
  } rstate_e;

  // Character timeout: four character times of 16 ticks per bit, minus one.
  function automatic logic [9:0] timeout_reload(input logic [1:0] wlen,
                                                input logic       pe,
                                                input logic       sb);
    logic [3:0] frame_bits;
    frame_bits = 4'd6 + {2'b00, wlen} + {3'b000, pe} + (sb ? 4'd2 : 4'd1);
    return {frame_bits, 6'b000000} - 10'd1;
  endfunction

endpackage

// File: rtl/uart_rfifo.sv
// rtl/uart_rfifo.sv - 16x11 receive FIFO with overrun and per-entry error tracking
// Purpose: stores received words {data, BI, FE, PE}; head word is combinational.
// Ports:
//   clk, wb_rst_ni   - clock, asynchronous active-low reset
//   i_data, i_push   - word to store, one-cycle push strobe
//   i_pop            - one-cycle pop strobe (ignored when empty)
//   i_fifo_reset     - synchronous flush, also clears error tracking and overrun
//   i_reset_status   - clears sticky overrun
//   o_data           - head word
//   o_count          - occupancy 0..16
//   o_overrun        - sticky: a push was dropped because the FIFO was full
//   o_error_bit      - some stored word has PE, FE or BI set
module uart_rfifo
  import uart_receiver_pkg::*;
(
  input  logic                           clk,
  input  logic                           wb_rst_ni,
  input  logic [UART_FIFO_REC_WIDTH-1:0] i_data,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_fifo_reset,
  input  logic                           i_reset_status,
  output logic [UART_FIFO_REC_WIDTH-1:0] o_data,
  output logic [UART_FIFO_COUNTER_W-1:0] o_count,
  output logic                           o_overrun,
  output logic                           o_error_bit
);

  logic [UART_FIFO_REC_WIDTH-1:0] r_mem [UART_FIFO_DEPTH];
  logic [UART_FIFO_POINTER_W-1:0] r_wp;
  logic [UART_FIFO_POINTER_W-1:0] r_rp;
  logic [UART_FIFO_COUNTER_W-1:0] r_count;
  logic [UART_FIFO_DEPTH-1:0]     r_err;
  logic                           r_overrun;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign w_full    = (r_count == 5'd16);
  assign w_do_pop  = i_pop && (r_count != 5'd0);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign w_drop    = i_push && !w_do_push;

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < UART_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else if (i_fifo_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 4'd1;
      end
      if (w_do_pop) begin
        r_rp <= r_rp + 4'd1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      // Pop clears first so a push into the same slot (full + pop) wins.
      if (w_do_pop)  r_err[r_rp] <= 1'b0;
      if (w_do_push) r_err[r_wp] <= |i_data[2:0];
    end
  end

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_reset_status || i_fifo_reset) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_data      = r_mem[r_rp];
  assign o_count     = r_count;
  assign o_overrun   = r_overrun;
  assign o_error_bit = |r_err;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x-oversampled UART receive path with FIFO and char timeout
// Purpose: recovers 5-8 bit characters framed by lcr, checks parity/framing/break,
//          stores them in uart_rfifo and runs the RX character-timeout counter.
// Ports:
//   clk, wb_rst_ni      - clock, asynchronous active-low reset
//   lcr                 - line control: [1:0] length, [2] stop, [3] PE, [4] EP, [5] SP
//   enable              - 16x baud tick, one clk wide
//   srx_pad_i           - asynchronous serial input
//   rf_pop, rx_reset    - FIFO pop strobe, synchronous FIFO flush
//   lsr_mask            - clears sticky overrun
//   rf_data_out         - FIFO head {data[7:0], BI, FE, PE}
//   rf_count            - FIFO occupancy
//   rf_overrun          - sticky overrun
//   rf_error_bit        - any stored word carries an error
//   rstate              - receiver state (debug)
//   counter_t           - character timeout counter
module uart_receiver
  import uart_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        wb_rst_ni,
  input  logic [7:0]  lcr,
  input  logic        enable,
  input  logic        srx_pad_i,
  input  logic        rf_pop,
  input  logic        rx_reset,
  input  logic        lsr_mask,
  output logic [10:0] rf_data_out,
  output logic [4:0]  rf_count,
  output logic        rf_overrun,
  output logic        rf_error_bit,
  output logic [2:0]  rstate,
  output logic [9:0]  counter_t
);

  logic        r_srx_meta;
  logic        r_srx;
  rstate_e     r_state;
  logic [3:0]  r_rcounter;
  logic [2:0]  r_bitidx;
  logic [7:0]  r_shift;
  logic        r_par_sample;
  logic        r_pe;
  logic        r_fe;
  logic [9:0]  r_counter_t;

  rstate_e     w_state_nxt;
  logic [3:0]  w_rcounter_nxt;
  logic [2:0]  w_bitidx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_par_nxt;
  logic        w_pe_nxt;
  logic        w_fe_nxt;
  logic        w_push;
  logic        w_bi;
  logic        w_exp_par;
  logic [2:0]  w_last_idx;
  logic [10:0] w_word;
  logic        w_lcr_unused;

  assign w_lcr_unused = ^lcr[7:6];

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_srx_meta <= 1'b1;
      r_srx      <= 1'b1;
    end else begin
      r_srx_meta <= srx_pad_i;
      r_srx      <= r_srx_meta;
    end
  end

  assign w_last_idx = 3'd4 + {1'b0, lcr[UART_LC_BITS +: 2]};

  always_comb begin
    case ({lcr[UART_LC_EP], lcr[UART_LC_SP]})
      2'b00:   w_exp_par = ~^r_shift;
      2'b01:   w_exp_par = 1'b1;
      2'b10:   w_exp_par = ^r_shift;
      default: w_exp_par = 1'b0;
    endcase
  end

  // Unused data bits stay zero, so a zero shift register means all-zero data.
  // r_par_sample is only written when parity is enabled.
  assign w_bi   = (r_shift == 8'h00) && !r_par_sample && r_fe;
  assign w_word = {r_shift, w_bi, r_fe, r_pe};

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= S_IDLE;
      r_rcounter   <= '0;
      r_bitidx     <= '0;
      r_shift      <= '0;
      r_par_sample <= 1'b0;
      r_pe         <= 1'b0;
      r_fe         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rcounter   <= w_rcounter_nxt;
      r_bitidx     <= w_bitidx_nxt;
      r_shift      <= w_shift_nxt;
      r_par_sample <= w_par_nxt;
      r_pe         <= w_pe_nxt;
      r_fe         <= w_fe_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rcounter_nxt = r_rcounter;
    w_bitidx_nxt   = r_bitidx;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par_sample;
    w_pe_nxt       = r_pe;
    w_fe_nxt       = r_fe;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !r_srx) begin
          w_state_nxt    = S_REC_START;
          w_rcounter_nxt = 4'd7;
        end
      end
      S_REC_START: begin
        if (enable) begin
          if (r_rcounter != 4'd0) begin
            w_rcounter_nxt = r_rcounter - 4'd1;
          end else if (r_srx) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt    = S_REC_BIT;
            w_rcounter_nxt = 4'd15;
            w_bitidx_nxt   = 3'd0;
            w_shift_nxt    = 8'h00;
            w_par_nxt      = 1'b0;
            w_pe_nxt       = 1'b0;
            w_fe_nxt       = 1'b0;
          end
        end
      end
      S_REC_BIT: begin
        if (enable) begin
          if (r_rcounter != 4'd0) begin
            w_rcounter_nxt = r_rcounter - 4'd1;
          end else begin
            w_shift_nxt[r_bitidx] = r_srx;
            w_rcounter_nxt        = 4'd15;
            w_bitidx_nxt          = r_bitidx + 3'd1;
            if (r_bitidx == w_last_idx) begin
              w_state_nxt = lcr[UART_LC_PE] ? S_REC_PARITY : S_REC_STOP;
            end
          end
        end
      end
      S_REC_PARITY: begin
        if (enable) begin
          if (r_rcounter != 4'd0) begin
            w_rcounter_nxt = r_rcounter - 4'd1;
          end else begin
            w_par_nxt      = r_srx;
            w_pe_nxt       = (r_srx != w_exp_par);
            w_rcounter_nxt = 4'd15;
            w_state_nxt    = S_REC_STOP;
          end
        end
      end
      S_REC_STOP: begin
        if (enable) begin
          if (r_rcounter != 4'd0) begin
            w_rcounter_nxt = r_rcounter - 4'd1;
          end else begin
            w_fe_nxt    = !r_srx;
            w_state_nxt = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = w_bi ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (enable && r_srx) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  uart_rfifo u_rfifo (
    .clk            (clk),
    .wb_rst_ni      (wb_rst_ni),
    .i_data         (w_word),
    .i_push         (w_push),
    .i_pop          (rf_pop),
    .i_fifo_reset   (rx_reset),
    .i_reset_status (lsr_mask),
    .o_data         (rf_data_out),
    .o_count        (rf_count),
    .o_overrun      (rf_overrun),
    .o_error_bit    (rf_error_bit)
  );

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_counter_t <= '0;
    end else if (w_push || rf_pop || (rf_count == 5'd0)) begin
      r_counter_t <= timeout_reload(lcr[UART_LC_BITS +: 2], lcr[UART_LC_PE], lcr[UART_LC_SB]);
    end else if (enable && (r_counter_t != 10'd0)) begin
      r_counter_t <= r_counter_t - 10'd1;
    end
  end

  assign counter_t = r_counter_t;
  assign rstate    = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int ENDIV    = 4;
  localparam int BIT_CLKS = 16 * ENDIV;

  logic        clk = 1'b0;
  logic        wb_rst_ni;
  logic [7:0]  lcr;
  logic        enable = 1'b0;
  logic        srx_pad_i;
  logic        rf_pop;
  logic        rx_reset;
  logic        lsr_mask;
  logic [10:0] rf_data_out;
  logic [4:0]  rf_count;
  logic        rf_overrun;
  logic        rf_error_bit;
  logic [2:0]  rstate;
  logic [9:0]  counter_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned div_cnt      = 0;
  logic [10:0] exp_q[$];
  logic        model_ovr    = 1'b0;

  uart_receiver dut (
    .clk          (clk),
    .wb_rst_ni    (wb_rst_ni),
    .lcr          (lcr),
    .enable       (enable),
    .srx_pad_i    (srx_pad_i),
    .rf_pop       (rf_pop),
    .rx_reset     (rx_reset),
    .lsr_mask     (lsr_mask),
    .rf_data_out  (rf_data_out),
    .rf_count     (rf_count),
    .rf_overrun   (rf_overrun),
    .rf_error_bit (rf_error_bit),
    .rstate       (rstate),
    .counter_t    (counter_t)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_cnt == ENDIV - 1) begin
      div_cnt = 0;
      enable  = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      enable  = 1'b0;
    end
  end

  // Reference word from the framing rules: parity by population count.
  function automatic logic [10:0] model_word(input logic [7:0] l, input logic [7:0] d,
                                             input logic par, input logic stop);
    int         n;
    int         ones;
    logic [7:0] dm;
    logic       exp_par;
    logic       pe;
    logic       fe;
    logic       bi;
    n    = 5 + int'(l[1:0]);
    dm   = d & 8'((1 << n) - 1);
    ones = $countones(dm);
    case ({l[4], l[5]})
      2'b00:   exp_par = (ones % 2 == 0);
      2'b01:   exp_par = 1'b1;
      2'b10:   exp_par = (ones % 2 == 1);
      default: exp_par = 1'b0;
    endcase
    pe = l[3] && (par != exp_par);
    fe = (stop == 1'b0);
    bi = (dm == 8'h00) && (!l[3] || par == 1'b0) && fe;
    return {dm, bi, fe, pe};
  endfunction

  function automatic void model_push(input logic [10:0] w);
    if (exp_q.size() < 16) exp_q.push_back(w);
    else model_ovr = 1'b1;
  endfunction

  task automatic drive_bit(input logic v);
    srx_pad_i = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    int n;
    n = 5 + int'(lcr[1:0]);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (lcr[3]) drive_bit(par);
    drive_bit(stop);
    if (lcr[2]) drive_bit(1'b1);
    srx_pad_i = 1'b1;
    repeat (2 * ENDIV) @(negedge clk);
    model_push(model_word(lcr, d, par, stop));
  endtask

  task automatic pulse_pop;
    rf_pop = 1'b1;
    @(negedge clk);
    rf_pop = 1'b0;
  endtask

  task automatic test_reset;
    wb_rst_ni = 1'b0; lcr = 8'h03; srx_pad_i = 1'b1;
    rf_pop = 1'b0; rx_reset = 1'b0; lsr_mask = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (rstate !== 3'd0) begin tests_failed++; $display("FAIL reset_rstate: got %0d want 0", rstate); end
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", rf_count); end
    tests_run++; if (rf_data_out !== 11'h000) begin tests_failed++; $display("FAIL reset_data: got %h want 000", rf_data_out); end
    tests_run++; if (rf_overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", rf_overrun); end
    tests_run++; if (rf_error_bit !== 1'b0) begin tests_failed++; $display("FAIL reset_error_bit: got %b want 0", rf_error_bit); end
    tests_run++; if (counter_t !== 10'd0) begin tests_failed++; $display("FAIL reset_counter_t: got %0d want 0", counter_t); end
    wb_rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (counter_t !== 10'd639) begin tests_failed++; $display("FAIL empty_reload: got %0d want 639", counter_t); end
  endtask

  task automatic test_8n1;
    lcr = 8'h03;
    send_frame(8'hA5, 1'b0, 1'b1);
    tests_run++; if (rf_count !== 5'd1) begin tests_failed++; $display("FAIL 8n1_count: got %0d want 1", rf_count); end
    tests_run++; if (rf_data_out !== 11'h528) begin tests_failed++; $display("FAIL 8n1_data: got %h want 528", rf_data_out); end
    tests_run++; if (rf_error_bit !== 1'b0) begin tests_failed++; $display("FAIL 8n1_error_bit: got %b want 0", rf_error_bit); end
    pulse_pop();
    void'(exp_q.pop_front());
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL 8n1_pop_count: got %0d want 0", rf_count); end
  endtask

  task automatic test_glitch;
    lcr = 8'h03;
    srx_pad_i = 1'b0;
    repeat (3 * ENDIV) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    tests_run++; if (rstate !== 3'd0) begin tests_failed++; $display("FAIL glitch_rstate: got %0d want 0", rstate); end
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL glitch_count: got %0d want 0", rf_count); end
  endtask

  task automatic test_parity;
    lcr = 8'h1A;
    send_frame(8'h41, 1'b1, 1'b1);
    tests_run++; if (rf_data_out !== 11'h209) begin tests_failed++; $display("FAIL 7e1_data: got %h want 209", rf_data_out); end
    tests_run++; if (rf_error_bit !== 1'b1) begin tests_failed++; $display("FAIL 7e1_error_bit: got %b want 1", rf_error_bit); end
    pulse_pop();
    void'(exp_q.pop_front());
    tests_run++; if (rf_error_bit !== 1'b0) begin tests_failed++; $display("FAIL 7e1_error_clear: got %b want 0", rf_error_bit); end
  endtask

  task automatic test_random_frames;
    logic [7:0]  d;
    logic        par;
    logic [10:0] w;
    for (int k = 0; k < 8; k++) begin
      lcr = {2'b00, 6'($urandom)};
      d   = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      send_frame(d, par, 1'b1);
      w = exp_q[0];
      tests_run++; if (rf_count !== 5'd1) begin tests_failed++; $display("FAIL rand_count[%0d]: got %0d want 1", k, rf_count); end
      tests_run++; if (rf_data_out !== w) begin tests_failed++; $display("FAIL rand_data[%0d] lcr=%h: got %h want %h", k, lcr, rf_data_out, w); end
      tests_run++; if (rf_error_bit !== (|w[2:0])) begin tests_failed++; $display("FAIL rand_error_bit[%0d]: got %b want %b", k, rf_error_bit, |w[2:0]); end
      pulse_pop();
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    lcr = {2'b00, 6'($urandom)};
    for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    tests_run++; if (rf_count !== 5'd4) begin tests_failed++; $display("FAIL b2b_count: got %0d want 4", rf_count); end
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (rf_data_out !== exp_q[0]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rf_data_out, exp_q[0]); end
      void'(exp_q.pop_front());
      pulse_pop();
    end
  endtask

  task automatic test_break;
    lcr = 8'h03;
    srx_pad_i = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    tests_run++; if (rf_count !== 5'd1) begin tests_failed++; $display("FAIL break_count: got %0d want 1", rf_count); end
    tests_run++; if (rf_data_out !== 11'h006) begin tests_failed++; $display("FAIL break_data: got %h want 006", rf_data_out); end
    tests_run++; if (rstate !== 3'd6) begin tests_failed++; $display("FAIL break_wait_high: got %0d want 6", rstate); end
    srx_pad_i = 1'b1;
    repeat (4 * ENDIV) @(negedge clk);
    tests_run++; if (rstate !== 3'd0) begin tests_failed++; $display("FAIL break_idle: got %0d want 0", rstate); end
    repeat (BIT_CLKS) @(negedge clk);
    tests_run++; if (rf_count !== 5'd1) begin tests_failed++; $display("FAIL break_single_push: got %0d want 1", rf_count); end
    pulse_pop();
  endtask

  task automatic test_overrun;
    lcr = 8'h03;
    model_ovr = 1'b0;
    for (int k = 0; k < 17; k++) send_frame(8'($urandom), 1'b0, 1'b1);
    tests_run++; if (rf_count !== 5'(exp_q.size())) begin tests_failed++; $display("FAIL ovr_count: got %0d want %0d", rf_count, exp_q.size()); end
    tests_run++; if (rf_overrun !== model_ovr) begin tests_failed++; $display("FAIL ovr_flag: got %b want %b", rf_overrun, model_ovr); end
    tests_run++; if (rf_data_out !== exp_q[0]) begin tests_failed++; $display("FAIL ovr_head: got %h want %h", rf_data_out, exp_q[0]); end
    lsr_mask = 1'b1;
    @(negedge clk);
    lsr_mask = 1'b0;
    tests_run++; if (rf_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", rf_overrun); end
    for (int k = 0; k < 16; k++) begin
      tests_run++; if (rf_data_out !== exp_q[0]) begin tests_failed++; $display("FAIL ovr_drain[%0d]: got %h want %h", k, rf_data_out, exp_q[0]); end
      void'(exp_q.pop_front());
      pulse_pop();
    end
    pulse_pop();
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL empty_pop_count: got %0d want 0", rf_count); end
  endtask

  task automatic test_rx_reset;
    lcr = 8'h1A;
    send_frame(8'h41, 1'b1, 1'b1);
    send_frame(8'h41, 1'b0, 1'b1);
    tests_run++; if (rf_error_bit !== 1'b1) begin tests_failed++; $display("FAIL rxr_error_before: got %b want 1", rf_error_bit); end
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    exp_q.delete();
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL rxr_count: got %0d want 0", rf_count); end
    tests_run++; if (rf_error_bit !== 1'b0) begin tests_failed++; $display("FAIL rxr_error_after: got %b want 0", rf_error_bit); end
  endtask

  task automatic test_timeout;
    int  n_en;
    bit  seen;
    logic [7:0] d;
    lcr = 8'h03;
    d   = 8'h3C;
    repeat (2) @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    srx_pad_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4 * BIT_CLKS && !seen; c++) begin
      @(negedge clk);
      if (rf_count == 5'd1) seen = 1'b1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL to_push: got no push within bound, want rf_count=1"); end
    tests_run++; if (counter_t !== 10'd639) begin tests_failed++; $display("FAIL to_push_reload: got %0d want 639", counter_t); end
    n_en = 0;
    while (n_en < 638) begin @(posedge clk); if (enable) n_en++; end
    @(negedge clk);
    tests_run++; if (counter_t !== 10'd1) begin tests_failed++; $display("FAIL to_638: got %0d want 1", counter_t); end
    n_en = 0;
    while (n_en < 6) begin @(posedge clk); if (enable) n_en++; end
    @(negedge clk);
    tests_run++; if (counter_t !== 10'd0) begin tests_failed++; $display("FAIL to_saturate: got %0d want 0", counter_t); end
    pulse_pop();
    tests_run++; if (counter_t !== 10'd639) begin tests_failed++; $display("FAIL to_pop_reload: got %0d want 639", counter_t); end
    n_en = 0;
    while (n_en < 10) begin @(posedge clk); if (enable) n_en++; end
    @(negedge clk);
    tests_run++; if (counter_t !== 10'd639) begin tests_failed++; $display("FAIL to_empty_hold: got %0d want 639", counter_t); end
  endtask

  task automatic test_reset_midframe;
    lcr = 8'h03;
    srx_pad_i = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    #2 wb_rst_ni = 1'b0;
    #1;
    tests_run++; if (rstate !== 3'd0) begin tests_failed++; $display("FAIL midframe_rstate: got %0d want 0", rstate); end
    srx_pad_i = 1'b1;
    @(negedge clk);
    wb_rst_ni = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    tests_run++; if (rf_count !== 5'd0) begin tests_failed++; $display("FAIL midframe_count: got %0d want 0", rf_count); end
    tests_run++; if (rstate !== 3'd0) begin tests_failed++; $display("FAIL midframe_idle: got %0d want 0", rstate); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_parity();
    test_random_frames();
    test_back_to_back();
    test_break();
    test_overrun();
    test_rx_reset();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
